rr_burst_scheduler: RTL and testbench

- Shares one downstream resource (bus port, memory channel) among NUM_REQ requesters, each of which issues a multi-beat burst.
- Round-robin arbitration selects a winner. The grant is then locked for that winner until its burst completes, counted in beats accepted by the resource.
- Sits between the requester front-ends and the shared datapath mux. It drives the mux select and tells the resource which beat is the last one.

---
 rtl/rr_burst_scheduler_if.sv | 17 +
 rtl/rr_burst_scheduler.sv | 93 +++++++++
 tb/tb_rr_burst_scheduler.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_burst_scheduler_if.sv
// Request/grant bundle between the requester front-ends and the burst scheduler.
interface rr_burst_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic                     beat;
  logic [NUM_REQ-1:0]       gnt;
  logic [IDX_W-1:0]         gnt_idx;
  logic                     busy;
  logic                     last;

  modport master (output req, req_len, beat, input gnt, gnt_idx, busy, last);
  modport slave  (input req, req_len, beat, output gnt, gnt_idx, busy, last);
endinterface

// File: rtl/rr_burst_scheduler.sv
// Round-robin arbiter that locks the grant to one requester for a whole
// multi-beat burst, counting beats accepted by the shared resource.
module rr_burst_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input logic                clk,
  input logic                rst,
  rr_burst_scheduler_if.slave bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     r_ptr;
  logic [LEN_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_last;

  logic [IDX_W-1:0]     w_win;
  logic [LEN_W-1:0]     w_win_len;
  logic                 w_any;
  logic                 w_abort;
  logic                 w_done;
  int                   w_best_d;

  // Winner is the requester closest after r_ptr in circular order.
  always_comb begin
    w_win     = '0;
    w_win_len = '0;
    w_best_d  = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req[i] && (((i + NUM_REQ - 1 - int'(r_ptr)) % NUM_REQ) < w_best_d)) begin
        w_best_d  = (i + NUM_REQ - 1 - int'(r_ptr)) % NUM_REQ;
        w_win     = IDX_W'(i);
        w_win_len = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign w_any   = |bus.req;
  assign w_abort = ~bus.req[r_idx];
  assign w_done  = bus.beat & (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_BUSY;
            r_gnt   <= NUM_REQ'(1) << w_win;
            r_idx   <= w_win;
            r_cnt   <= w_win_len;
            r_busy  <= 1'b1;
            r_last  <= (w_win_len == '0);
          end
        end
        S_BUSY: begin
          // Abort and completion both release the grant and advance the pointer.
          if (w_abort || w_done) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
            r_ptr   <= r_idx;
          end else if (bus.beat) begin
            r_cnt  <= r_cnt - LEN_W'(1);
            r_last <= (r_cnt == LEN_W'(1));
          end
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_idx = r_idx;
  assign bus.busy    = r_busy;
  assign bus.last    = r_last;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Scoreboard bench for rr_burst_scheduler: directed scenarios plus random traffic
// checked against a burst-level reference model.
module tb_rr_burst_scheduler;

  localparam int N  = 4;
  localparam int LW = 4;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [1:0]   idx;
    logic         busy;
    logic         last;
  } exp_t;

  logic clk;
  logic rst;

  rr_burst_scheduler_if #(.NUM_REQ(N), .LEN_W(LW)) bus ();

  rr_burst_scheduler #(.NUM_REQ(N), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];
  int   gnt_log[$];

  // Reference model: owner, beats still to be accepted, last-winner pointer.
  int m_busy, m_owner, m_left, m_ptr;

  function automatic int pick(input logic [N-1:0] rq, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (rq[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] rq,
                            input logic [N*LW-1:0] ln, input logic b);
    int w;
    if (r) begin
      m_busy = 0; m_owner = 0; m_left = 0; m_ptr = N - 1;
    end else if (m_busy == 0) begin
      w = pick(rq, m_ptr);
      if (w >= 0) begin
        m_busy  = 1;
        m_owner = w;
        m_left  = int'(ln[w*LW +: LW]) + 1;
      end
    end else if (!rq[m_owner]) begin
      m_busy = 0;
      m_ptr  = m_owner;
    end else if (b) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0;
        m_ptr  = m_owner;
      end
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] rq,
                       input logic [N*LW-1:0] ln, input logic b);
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.req     = rq;
    bus.req_len = ln;
    bus.beat    = b;
    model_step(r, rq, ln, b);
    e.busy = (m_busy != 0);
    e.gnt  = m_busy != 0 ? (N'(1) << m_owner) : '0;
    e.idx  = m_busy != 0 ? 2'(m_owner) : 2'd0;
    e.last = (m_busy != 0) && (m_left == 1);
    exp_q.push_back(e);
  endtask

  task automatic check_log(input string nm, input int pos, input int expv);
    checks++;
    if (gnt_log.size() <= pos) begin
      failures++;
      $display("FAIL %s: grant #%0d missing (only %0d grants), required %0d",
               nm, pos, gnt_log.size(), expv);
    end else if (gnt_log[pos] != expv) begin
      failures++;
      $display("FAIL %s: grant #%0d went to %0d, required %0d", nm, pos, gnt_log[pos], expv);
    end
  endtask

  // Monitor: compares every cycle against the scoreboard and logs new grants.
  logic [N-1:0] prev_gnt = '0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.gnt !== e.gnt || bus.busy !== e.busy || bus.last !== e.last ||
            (e.busy && bus.gnt_idx !== e.idx)) begin
          failures++;
          $display("FAIL outputs @%0t: gnt=%b idx=%0d busy=%b last=%b, required gnt=%b idx=%0d busy=%b last=%b",
                   $time, bus.gnt, bus.gnt_idx, bus.busy, bus.last, e.gnt, e.idx, e.busy, e.last);
        end
      end
      checks++;
      if (!$onehot0(bus.gnt) || (bus.busy !== (|bus.gnt)) || (bus.last && !bus.busy)) begin
        failures++;
        $display("FAIL invariant @%0t: gnt=%b busy=%b last=%b", $time, bus.gnt, bus.busy, bus.last);
      end
      if (bus.gnt != '0 && prev_gnt == '0) gnt_log.push_back(int'(bus.gnt_idx));
      prev_gnt = bus.gnt;
    end
  end

  initial begin
    logic [N-1:0]    rq;
    logic [N*LW-1:0] ln;
    rst         = 1'b1;
    bus.req     = '0;
    bus.req_len = '0;
    bus.beat    = 1'b0;

    // Single request from requester 2, len field 2, then re-grant while held.
    drive(1, 4'b0000, '0, 0);
    drive(1, 4'b0000, '0, 0);
    gnt_log.delete();
    repeat (8) drive(0, 4'b0100, 16'h0200, 1);
    check_log("single_first", 0, 2);
    check_log("single_regrant", 1, 2);

    // Rotation with all requesters active and single-beat bursts.
    drive(1, 4'b0000, '0, 0);
    gnt_log.delete();
    repeat (11) drive(0, 4'b1111, 16'h0000, 1);
    for (int i = 0; i < 5; i++) check_log("rotation", i, i % N);

    // Wrap and skip: requester 3 finishes, then only 1 and 3 request.
    drive(1, 4'b0000, '0, 0);
    gnt_log.delete();
    drive(0, 4'b1000, 16'h0000, 1);
    repeat (8) drive(0, 4'b1010, 16'h0000, 1);
    check_log("wrap_first", 0, 3);
    check_log("wrap_skip", 1, 1);
    check_log("wrap_next", 2, 3);

    // Beat stalls on a 4-beat burst from requester 0.
    drive(1, 4'b0000, '0, 0);
    drive(0, 4'b0001, 16'h0003, 0);
    drive(0, 4'b0001, 16'h0003, 1);
    drive(0, 4'b0001, 16'h0003, 0);
    drive(0, 4'b0001, 16'h0003, 0);
    drive(0, 4'b0001, 16'h0003, 1);
    drive(0, 4'b0001, 16'h0003, 1);
    drive(0, 4'b0001, 16'h0003, 0);
    drive(0, 4'b0001, 16'h0003, 1);
    drive(0, 4'b0000, 16'h0003, 0);
    drive(0, 4'b0000, 16'h0003, 0);

    // Abort by requester 2 after two beats; requester 3 then wins.
    drive(1, 4'b0000, '0, 0);
    gnt_log.delete();
    repeat (3) drive(0, 4'b0100, 16'h0700, 1);
    drive(0, 4'b1000, 16'h0700, 1);
    repeat (4) drive(0, 4'b1000, 16'h0000, 1);
    check_log("abort_first", 0, 2);
    check_log("abort_next", 1, 3);

    // Reset in the middle of a burst from requester 1 (beat_cnt at 5).
    drive(1, 4'b0000, '0, 0);
    repeat (3) drive(0, 4'b0010, 16'h0070, 1);
    drive(1, 4'b1111, 16'h0070, 1);
    gnt_log.delete();
    repeat (4) drive(0, 4'b1111, 16'h0000, 1);
    check_log("reset_mid", 0, 0);

    // Random traffic; the owner usually holds its request, occasionally aborts.
    for (int c = 0; c < 3000; c++) begin
      rq = N'($urandom);
      if (m_busy != 0 && $urandom_range(0, 19) != 0) rq[m_owner] = 1'b1;
      ln = (N*LW)'($urandom);
      drive(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, rq, ln,
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

    drive(1, 4'b0000, '0, 0);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
